// File: rtl/tytra_leaf_pipe_node_if.sv
// Stream bus of the TyBEC leaf map node: two joined operand inputs, one result output.
//
// Handshake: an operand pair transfers at a rising clk edge when ivalid_in1,
// ivalid_in2 (unless in2 is a constant) and iready are all high. A result
// transfers at a rising edge when ovalid and oready are both high. A producer
// holding a valid keeps its data stable until the transfer happens. ovalid and
// out1 stay stable while oready is low. iready depends on registered state only.
interface tytra_leaf_pipe_node_if #(
   parameter int STREAMW = 32
);
   logic               ivalid_in1;
   logic [STREAMW-1:0] in1;
   logic               ivalid_in2;
   logic [STREAMW-1:0] in2;
   logic               iready;
   logic               ovalid;
   logic [STREAMW-1:0] out1;
   logic               oready;

   // Upstream/downstream side (drives operands and oready).
   modport master (
      output ivalid_in1, in1, ivalid_in2, in2, oready,
      input  iready, ovalid, out1
   );

   // Node side.
   modport slave (
      input  ivalid_in1, in1, ivalid_in2, in2, oready,
      output iready, ovalid, out1
   );
endinterface

// File: rtl/tytra_leaf_pipe_node.sv
// tytra_leaf_pipe_node: generic leaf map node. Joins in1/in2, applies OP through
// a free-running LAT-stage pipeline and buffers results in a DEPTH=LAT+2 entry
// first-word-fall-through FIFO. A credit counter (pipeline + FIFO occupancy)
// gates iready so a result always finds room in the FIFO.
// Optional build macro TYTRA_LEAF_SAT_EN: signed saturation for add/sub.
module tytra_leaf_pipe_node #(
   parameter int                 STREAMW   = 32,
   parameter int                 LAT       = 4,
   parameter int                 OP        = 0,
   parameter int                 CONST_IN2 = 0,
   parameter logic [STREAMW-1:0] CONST_VAL = '0
) (
   input logic                   clk,
   input logic                   rst,
   tytra_leaf_pipe_node_if.slave bus
);
   localparam int DEPTH = LAT + 2;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int PW    = $clog2(DEPTH);

   logic               op2_valid;
   logic [STREAMW-1:0] op2;
   logic               jvalid;
   logic               accept;
   logic               iready;
   logic [STREAMW-1:0] res;

   // Operand join: both operands are consumed together, never one alone.
   assign op2_valid = (CONST_IN2 != 0) ? 1'b1 : bus.ivalid_in2;
   assign op2       = (CONST_IN2 != 0) ? CONST_VAL : bus.in2;
   assign jvalid    = bus.ivalid_in1 & op2_valid;
   assign accept    = jvalid & iready;

`ifdef TYTRA_LEAF_SAT_EN
   localparam logic [STREAMW-1:0] SMAX = {1'b0, {(STREAMW-1){1'b1}}};
   localparam logic [STREAMW-1:0] SMIN = {1'b1, {(STREAMW-1){1'b0}}};
   logic [STREAMW:0] a_x;
   logic [STREAMW:0] b_x;
   logic [STREAMW:0] s_x;

   // Operator with one guard bit; add/sub clamp on signed overflow.
   always_comb begin
      res = bus.in1;
      a_x = {bus.in1[STREAMW-1], bus.in1};
      b_x = {op2[STREAMW-1], op2};
      s_x = (OP == 1) ? (a_x - b_x) : (a_x + b_x);
      case (OP)
         0, 1: begin
            if (s_x[STREAMW] != s_x[STREAMW-1]) res = s_x[STREAMW] ? SMIN : SMAX;
            else                                res = s_x[STREAMW-1:0];
         end
         2:       res = bus.in1 * op2;
         default: res = bus.in1;
      endcase
   end
`else
   // Operator, wrapping modulo 2^STREAMW.
   always_comb begin
      res = bus.in1;
      case (OP)
         0:       res = bus.in1 + op2;
         1:       res = bus.in1 - op2;
         2:       res = bus.in1 * op2;
         default: res = bus.in1;
      endcase
   end
`endif

   // Pipeline: one valid bit per stage, never stalls; bubbles are valid=0.
   logic [LAT-1:0]     pv_q;
   logic [LAT-1:0]     pv_d;
   logic [STREAMW-1:0] pd_q [LAT];

   // Next valid vector: accept enters stage 0, every stage shifts by one.
   always_comb begin
      pv_d    = '0;
      pv_d[0] = accept;
      for (int k = 1; k < LAT; k++) pv_d[k] = pv_q[k-1];
   end

   // Valid bits are cleared by reset so in-flight elements are discarded.
   always_ff @(posedge clk) begin
      if (rst) pv_q <= '0;
      else     pv_q <= pv_d;
   end

   // Data stages carry no reset; only their valid bits matter.
   always_ff @(posedge clk) begin
      pd_q[0] <= res;
      for (int k = 1; k < LAT; k++) pd_q[k] <= pd_q[k-1];
   end

   // Output FIFO and credit counter.
   logic [STREAMW-1:0] mem_q [DEPTH];
   logic [PW-1:0]      wptr_q, wptr_d;
   logic [PW-1:0]      rptr_q, rptr_d;
   logic [CW-1:0]      fcnt_q, fcnt_d;
   logic [CW-1:0]      occ_q, occ_d;
   logic               wr;
   logic               ovalid;
   logic               pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign wr     = pv_q[LAT-1];
   assign ovalid = (fcnt_q != '0);
   assign pop    = ovalid & bus.oready;
   assign iready = (occ_q < CW'(DEPTH));

   // Next pointers and counts; occupancy moves by +accept-pop.
   always_comb begin
      wptr_d = wr  ? ptr_inc(wptr_q) : wptr_q;
      rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;
      fcnt_d = fcnt_q + CW'(wr) - CW'(pop);
      occ_d  = occ_q + CW'(accept) - CW'(pop);
   end

   // Pointer/count registers; reset empties the FIFO and clears credit.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         fcnt_q <= '0;
         occ_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         fcnt_q <= fcnt_d;
         occ_q  <= occ_d;
      end
   end

   // FIFO storage write; credit guarantees the slot is free.
   always_ff @(posedge clk) begin
      if (wr) mem_q[wptr_q] <= pd_q[LAT-1];
   end

   assign bus.iready = iready;
   assign bus.ovalid = ovalid;
   assign bus.out1   = ovalid ? mem_q[rptr_q] : '0;
endmodule
